// File: rtl/pc_gen.sv
// Fetch PC generator: next-PC selection, EPC capture and user/handler mode.
// Drives the instruction memory address directly from the pc register.
module pc_gen #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
  parameter logic [31:0] USER_LIMIT    = 32'h0000_0FFC,
  parameter logic [31:0] HANDLER_LIMIT = 32'h8000_057C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        in_handler,
  output logic        addr_err,
  output logic        exc_dropped
);

  typedef enum logic {
    USER    = 1'b0,
    HANDLER = 1'b1
  } mode_t;

  mode_t mode;

  logic exc_take;
  logic ret_take;

  assign exc_take = exception && (mode == USER);
  assign ret_take = eret && (mode == HANDLER);

  assign pc_plus4   = pc + 32'd4;
  assign in_handler = (mode == HANDLER);

  // Flag only; the pipeline raises the actual fetch exception.
  assign addr_err = (pc[1:0] != 2'b00)
    || ((mode == USER) && (pc > USER_LIMIT))
    || ((mode == HANDLER)
        && ((pc < EXC_VECTOR) || (pc > HANDLER_LIMIT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      epc         <= 32'h0;
      mode        <= USER;
      exc_dropped <= 1'b0;
    end else begin
      exc_dropped <= exception && (mode == HANDLER);
      priority case (1'b1)
        exc_take: begin
          epc  <= exc_pc;
          pc   <= EXC_VECTOR;
          mode <= HANDLER;
        end
        ret_take: begin
          pc   <= epc;
          mode <= USER;
        end
        stall:        pc <= pc;
        jr:           pc <= jr_target;
        jump:         pc <= jump_target;
        branch_taken: pc <= branch_target;
        default:      pc <= pc_plus4;
      endcase
    end
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generation stage sitting directly upstream of the instruction memory in the 5-stage MIPS pipeline. Holds the architectural fetch PC, selects the next PC (sequential, branch, jump, register-jump, exception vector, exception return) under a fixed priority, and tracks user/handler mode with an EPC register. The `pc` output drives the instruction memory address directly; the memory samples it on the following negative clock edge.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `EXC_VECTOR`, 32'h8000_0180: exception handler entry address.
- `USER_LIMIT`, 32'h0000_0FFC: highest legal word address in user instruction space.
- `HANDLER_LIMIT`, 32'h8000_057C: highest legal word address in handler space.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit hold request.
- `branch_taken`  in  1  ID-stage branch resolved taken.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  J/JAL in ID.
- `jump_target`  in  32  assembled jump destination.
- `jr`  in  1  JR/JALR in ID.
- `jr_target`  in  32  register value for JR.
- `exception`  in  1  exception raised by a later stage.
- `exc_pc`  in  32  PC of the faulting instruction.
- `eret`  in  1  ERET decoded in ID.
- `pc`  out  32  current fetch address (registered).
- `pc_plus4`  out  32  `pc + 4`, combinational.
- `epc`  out  32  saved exception PC (registered).
- `in_handler`  out  1  1 while in handler mode (registered).
- `addr_err`  out  1  current `pc` illegal (combinational decode of `pc`).
- `exc_dropped`  out  1  one-cycle pulse: exception ignored because already in handler.

## Operation
- State: `pc`, `epc`, mode FSM {USER, HANDLER}.
- Reset: `pc`=RESET_PC, `epc`=0, mode=USER, `exc_dropped`=0; `in_handler`=0.
- Next-PC priority per rising edge (first match wins):
  1. `exception` in USER: `epc`<=`exc_pc`, `pc`<=EXC_VECTOR, mode->HANDLER.
  2. `exception` in HANDLER: not taken; `exc_dropped`<=1; evaluation continues at item 3.
  3. `eret` in HANDLER: `pc`<=`epc`, mode->USER. `eret` in USER: ignored (continues at 4).
  4. `stall`: `pc` held.
  5. `jr`: `pc`<=`jr_target`.
  6. `jump`: `pc`<=`jump_target`.
  7. `branch_taken`: `pc`<=`branch_target`.
  8. else `pc`<=`pc`+4 (32-bit wrap, no carry out).
- Exception and ERET override `stall`; branch/jump/jr are ignored under `stall` (ID re-presents them after the stall).
- `epc` written only by item 1; otherwise holds.
- Targets are loaded unmodified; no alignment masking.
- `addr_err`=1 when `pc[1:0]`!=0, or USER and `pc`>USER_LIMIT, or HANDLER and (`pc`<EXC_VECTOR or `pc`>HANDLER_LIMIT). Flag only; `pc_gen` does not self-trap. Downstream raises `exception`.
- `exc_dropped` deasserts the cycle after any cycle it was set, unless re-triggered.

## Timing
- Redirect latency: control inputs sampled at rising edge N; new `pc` visible after edge N; instruction memory returns it at the negedge within cycle N+1.
- `pc_plus4` follows `pc` combinationally, zero cycles.
- `in_handler` changes on the same edge as the vector/return `pc` load.
- `rst` asserted mid-operation: next edge forces reset values regardless of all other inputs, including `exception` and `stall`.
- No handshake; all inputs are level-sampled once per edge and must be stable at the rising edge.

## Test plan
- Reset then 4 free-running cycles -> `pc` = 0x0, 0x4, 0x8, 0xC; `in_handler`=0; `addr_err`=0.
- At `pc`=0x10 assert `stall` 2 cycles with `branch_taken`=1, target 0x40 -> `pc` holds 0x10 twice; on release with branch still asserted -> 0x40.
- At `pc`=0x20 assert `exception`, `exc_pc`=0x18, and `stall`=1 -> next `pc`=0x8000_0180, `epc`=0x18, `in_handler`=1; 3 cycles later `eret` -> `pc`=0x18, `in_handler`=0.
- In HANDLER assert `exception` and `eret` together -> `exc_dropped` pulses 1 cycle, `pc`<=`epc`, mode USER, `epc` unchanged.
- `jump`=1, target 0x1000 -> `pc`=0x1000, `addr_err`=1; `jr` target 0x22 -> `addr_err`=1 (misaligned); `jr`,`jump`,`branch_taken` all set -> `jr_target` wins.
- Assert `rst` while in HANDLER with `exception`=1 -> `pc`=0x0, `epc`=0, `in_handler`=0, `exc_dropped`=0.
